// File: rtl/dram_sc_rep_pkg.sv
// rtl/dram_sc_rep_pkg.sv - shared widths, control-bit indices and request group type
package dram_sc_rep_pkg;

  localparam int DEF_DW  = 128;
  localparam int DEF_EW  = 28;
  localparam int DEF_WDW = 64;

  localparam int ADDR_HI = 39;
  localparam int ADDR_LO = 5;
  localparam int ID_W    = 3;
  localparam int CHUNK_W = 2;

  // Bit positions of the unconditionally flopped control vector
  localparam int CTL_W       = 11;
  localparam int CB_VLD_R2   = 0;
  localparam int CB_VLD_R0   = 1;
  localparam int CB_RD_ACK   = 2;
  localparam int CB_WR_ACK   = 3;
  localparam int CB_SECC     = 4;
  localparam int CB_MECC     = 5;
  localparam int CB_SCB_MECC = 6;
  localparam int CB_SCB_SECC = 7;
  localparam int CB_RD_REQ   = 8;
  localparam int CB_WR_REQ   = 9;
  localparam int CB_VLD_R5   = 10;

  typedef struct packed {
    logic [ADDR_HI:ADDR_LO] addr;
    logic [ID_W-1:0]        id;
    logic                   dummy;
  } rep_req_t;

  function automatic logic even_par32(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/dram_sc_rep_stage.sv
// rtl/dram_sc_rep_stage.sv - one valid-qualified payload register stage
module dram_sc_rep_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (vld)
      q <= d;
  end

endmodule

// File: rtl/dram_sc_rep_pipe.sv
// rtl/dram_sc_rep_pipe.sv - pipelined DRAM<->L2 repeater column; DRAM_SC_REP_PAR_EN adds return-data parity
module dram_sc_rep_pipe
  import dram_sc_rep_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter int DW        = DEF_DW,
  parameter int EW        = DEF_EW,
  parameter int WDW       = DEF_WDW,
  parameter int MAX_OUTST = 8,
  localparam int CW       = $clog2(MAX_OUTST + 1)
) (
  input  logic                   rclk,
  input  logic                   reset,
  input  logic                   dram_scbuf_data_vld_r2,
  input  logic [DW-1:0]          dram_scbuf_data_r2,
  input  logic [EW-1:0]          dram_scbuf_ecc_r2,
  input  logic                   dram_sctag_data_vld_r0,
  input  logic [CHUNK_W-1:0]     dram_sctag_chunk_id_r0,
  input  logic [ID_W-1:0]        dram_sctag_rd_req_id_r0,
  input  logic                   dram_sctag_rd_ack,
  input  logic                   dram_sctag_wr_ack,
  input  logic                   dram_sctag_secc_err_r2,
  input  logic                   dram_sctag_mecc_err_r2,
  input  logic                   dram_sctag_scb_mecc_err,
  input  logic                   dram_sctag_scb_secc_err,
  input  logic                   sctag_dram_rd_req,
  input  logic                   sctag_dram_rd_dummy_req,
  input  logic                   sctag_dram_wr_req,
  input  logic [ID_W-1:0]        sctag_dram_rd_req_id,
  input  logic [ADDR_HI:ADDR_LO] sctag_dram_addr,
  input  logic                   scbuf_dram_data_vld_r5,
  input  logic [WDW-1:0]         scbuf_dram_wr_data_r5,
  input  logic                   scbuf_dram_data_mecc_r5,
  output logic                   dram_scbuf_data_vld_r2_buf,
  output logic [DW-1:0]          dram_scbuf_data_r2_buf,
  output logic [EW-1:0]          dram_scbuf_ecc_r2_buf,
  output logic                   dram_sctag_data_vld_r0_buf,
  output logic [CHUNK_W-1:0]     dram_sctag_chunk_id_r0_buf,
  output logic [ID_W-1:0]        dram_sctag_rd_req_id_r0_buf,
  output logic                   dram_sctag_rd_ack_buf,
  output logic                   dram_sctag_wr_ack_buf,
  output logic                   dram_sctag_secc_err_r2_buf,
  output logic                   dram_sctag_mecc_err_r2_buf,
  output logic                   dram_sctag_scb_mecc_err_buf,
  output logic                   dram_sctag_scb_secc_err_buf,
  output logic                   sctag_dram_rd_req_buf,
  output logic                   sctag_dram_rd_dummy_req_buf,
  output logic                   sctag_dram_wr_req_buf,
  output logic [ID_W-1:0]        sctag_dram_rd_req_id_buf,
  output logic [ADDR_HI:ADDR_LO] sctag_dram_addr_buf,
  output logic                   scbuf_dram_data_vld_r5_buf,
  output logic [WDW-1:0]         scbuf_dram_wr_data_r5_buf,
  output logic                   scbuf_dram_data_mecc_r5_buf,
  output logic [CW-1:0]          rep_rd_outstanding,
  output logic                   rep_ovf_err,
  output logic                   rep_unf_err,
  output logic                   rep_par_err
);

`ifdef DRAM_SC_REP_PAR_EN
  localparam int PW  = DW / 32;
  localparam int G1W = DW + EW + PW;
`else
  localparam int G1W = DW + EW;
`endif
  localparam int G2W = CHUNK_W + ID_W;
  localparam int G3W = $bits(rep_req_t);
  localparam int G4W = WDW + 1;

  logic [CTL_W-1:0]              ctl_in, ctl_out;
  logic [STAGES-1:0][CTL_W-1:0]  ctl_q;
  logic [G1W-1:0]                g1_in;
  logic [G2W-1:0]                g2_in;
  rep_req_t                      g3_in, g3_out;
  logic [G4W-1:0]                g4_in;
  logic [STAGES-1:0][G1W-1:0]    g1_q;
  logic [STAGES-1:0][G2W-1:0]    g2_q;
  logic [STAGES-1:0][G3W-1:0]    g3_q;
  logic [STAGES-1:0][G4W-1:0]    g4_q;

  assign ctl_in = {scbuf_dram_data_vld_r5, sctag_dram_wr_req, sctag_dram_rd_req,
                   dram_sctag_scb_secc_err, dram_sctag_scb_mecc_err,
                   dram_sctag_mecc_err_r2, dram_sctag_secc_err_r2,
                   dram_sctag_wr_ack, dram_sctag_rd_ack,
                   dram_sctag_data_vld_r0, dram_scbuf_data_vld_r2};

  // Control pulses and qualifiers shift every cycle; payloads below follow them
  always_ff @(posedge rclk) begin
    if (reset) begin
      ctl_q <= '0;
    end else begin
      ctl_q[0] <= ctl_in;
      for (int k = 1; k < STAGES; k++)
        ctl_q[k] <= ctl_q[k-1];
    end
  end

  assign ctl_out = ctl_q[STAGES-1];

  assign g2_in       = {dram_sctag_chunk_id_r0, dram_sctag_rd_req_id_r0};
  assign g3_in.addr  = sctag_dram_addr;
  assign g3_in.id    = sctag_dram_rd_req_id;
  assign g3_in.dummy = sctag_dram_rd_dummy_req;
  assign g4_in       = {scbuf_dram_wr_data_r5, scbuf_dram_data_mecc_r5};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic           q_r2, q_r0, q_req, q_r5;
    logic [G1W-1:0] d1;
    logic [G2W-1:0] d2;
    logic [G3W-1:0] d3;
    logic [G4W-1:0] d4;

    if (k == 0) begin : g_first
      assign q_r2  = dram_scbuf_data_vld_r2;
      assign q_r0  = dram_sctag_data_vld_r0;
      assign q_req = sctag_dram_rd_req | sctag_dram_wr_req;
      assign q_r5  = scbuf_dram_data_vld_r5;
      assign d1 = g1_in;
      assign d2 = g2_in;
      assign d3 = g3_in;
      assign d4 = g4_in;
    end else begin : g_next
      assign q_r2  = ctl_q[k-1][CB_VLD_R2];
      assign q_r0  = ctl_q[k-1][CB_VLD_R0];
      assign q_req = ctl_q[k-1][CB_RD_REQ] | ctl_q[k-1][CB_WR_REQ];
      assign q_r5  = ctl_q[k-1][CB_VLD_R5];
      assign d1 = g1_q[k-1];
      assign d2 = g2_q[k-1];
      assign d3 = g3_q[k-1];
      assign d4 = g4_q[k-1];
    end

    dram_sc_rep_stage #(.W(G1W)) u_ret (.clk(rclk), .reset(reset), .vld(q_r2),  .d(d1), .q(g1_q[k]));
    dram_sc_rep_stage #(.W(G2W)) u_tag (.clk(rclk), .reset(reset), .vld(q_r0),  .d(d2), .q(g2_q[k]));
    dram_sc_rep_stage #(.W(G3W)) u_req (.clk(rclk), .reset(reset), .vld(q_req), .d(d3), .q(g3_q[k]));
    dram_sc_rep_stage #(.W(G4W)) u_wr  (.clk(rclk), .reset(reset), .vld(q_r5),  .d(d4), .q(g4_q[k]));
  end

  assign dram_scbuf_data_vld_r2_buf  = ctl_out[CB_VLD_R2];
  assign dram_sctag_data_vld_r0_buf  = ctl_out[CB_VLD_R0];
  assign dram_sctag_rd_ack_buf       = ctl_out[CB_RD_ACK];
  assign dram_sctag_wr_ack_buf       = ctl_out[CB_WR_ACK];
  assign dram_sctag_secc_err_r2_buf  = ctl_out[CB_SECC];
  assign dram_sctag_mecc_err_r2_buf  = ctl_out[CB_MECC];
  assign dram_sctag_scb_mecc_err_buf = ctl_out[CB_SCB_MECC];
  assign dram_sctag_scb_secc_err_buf = ctl_out[CB_SCB_SECC];
  assign sctag_dram_rd_req_buf       = ctl_out[CB_RD_REQ];
  assign sctag_dram_wr_req_buf       = ctl_out[CB_WR_REQ];
  assign scbuf_dram_data_vld_r5_buf  = ctl_out[CB_VLD_R5];

  assign dram_scbuf_data_r2_buf = g1_q[STAGES-1][G1W-1 -: DW];
  assign dram_scbuf_ecc_r2_buf  = g1_q[STAGES-1][G1W-DW-1 -: EW];

  assign {dram_sctag_chunk_id_r0_buf, dram_sctag_rd_req_id_r0_buf} = g2_q[STAGES-1];

  assign g3_out                      = g3_q[STAGES-1];
  assign sctag_dram_addr_buf         = g3_out.addr;
  assign sctag_dram_rd_req_id_buf    = g3_out.id;
  assign sctag_dram_rd_dummy_req_buf = g3_out.dummy;

  assign {scbuf_dram_wr_data_r5_buf, scbuf_dram_data_mecc_r5_buf} = g4_q[STAGES-1];

`ifdef DRAM_SC_REP_PAR_EN
  logic [PW-1:0] par_in, par_chk;

  // Parity rides in the low bits of the return group and is checked at exit
  always_comb begin
    par_in  = '0;
    par_chk = '0;
    for (int i = 0; i < PW; i++) begin
      par_in[i]  = even_par32(dram_scbuf_data_r2[32*i +: 32]);
      par_chk[i] = even_par32(dram_scbuf_data_r2_buf[32*i +: 32]);
    end
  end

  assign g1_in       = {dram_scbuf_data_r2, dram_scbuf_ecc_r2, par_in};
  assign rep_par_err = ctl_out[CB_VLD_R2] & (|(par_chk ^ g1_q[STAGES-1][PW-1:0]));
`else
  assign g1_in       = {dram_scbuf_data_r2, dram_scbuf_ecc_r2};
  assign rep_par_err = 1'b0;
`endif

  // Requests count at entry, acks retire at exit
  logic inc, dec;
  assign inc = sctag_dram_rd_req & ~sctag_dram_rd_dummy_req;
  assign dec = ctl_out[CB_RD_ACK];

  always_ff @(posedge rclk) begin
    if (reset) begin
      rep_rd_outstanding <= '0;
      rep_ovf_err        <= 1'b0;
      rep_unf_err        <= 1'b0;
    end else if (inc && !dec) begin
      if (rep_rd_outstanding == CW'(MAX_OUTST))
        rep_ovf_err <= 1'b1;
      else
        rep_rd_outstanding <= rep_rd_outstanding + CW'(1);
    end else if (dec && !inc) begin
      if (rep_rd_outstanding == '0)
        rep_unf_err <= 1'b1;
      else
        rep_rd_outstanding <= rep_rd_outstanding - CW'(1);
    end
  end

endmodule

// File: tb/tb_dram_sc_rep_pipe.sv
// tb/tb_dram_sc_rep_pipe.sv - directed self-checking bench for dram_sc_rep_pipe
module tb_dram_sc_rep_pipe;

  localparam int ST  = 2;
  localparam int DW  = 128;
  localparam int EW  = 28;
  localparam int WDW = 64;
  localparam int MO  = 8;
  localparam int CW  = 4;

  logic rclk = 1'b0;
  logic reset;
  logic dram_scbuf_data_vld_r2;
  logic [DW-1:0] dram_scbuf_data_r2;
  logic [EW-1:0] dram_scbuf_ecc_r2;
  logic dram_sctag_data_vld_r0;
  logic [1:0] dram_sctag_chunk_id_r0;
  logic [2:0] dram_sctag_rd_req_id_r0;
  logic dram_sctag_rd_ack, dram_sctag_wr_ack, dram_sctag_secc_err_r2, dram_sctag_mecc_err_r2;
  logic dram_sctag_scb_mecc_err, dram_sctag_scb_secc_err;
  logic sctag_dram_rd_req, sctag_dram_rd_dummy_req, sctag_dram_wr_req;
  logic [2:0] sctag_dram_rd_req_id;
  logic [39:5] sctag_dram_addr;
  logic scbuf_dram_data_vld_r5;
  logic [WDW-1:0] scbuf_dram_wr_data_r5;
  logic scbuf_dram_data_mecc_r5;

  logic dram_scbuf_data_vld_r2_buf;
  logic [DW-1:0] dram_scbuf_data_r2_buf;
  logic [EW-1:0] dram_scbuf_ecc_r2_buf;
  logic dram_sctag_data_vld_r0_buf;
  logic [1:0] dram_sctag_chunk_id_r0_buf;
  logic [2:0] dram_sctag_rd_req_id_r0_buf;
  logic dram_sctag_rd_ack_buf, dram_sctag_wr_ack_buf, dram_sctag_secc_err_r2_buf, dram_sctag_mecc_err_r2_buf;
  logic dram_sctag_scb_mecc_err_buf, dram_sctag_scb_secc_err_buf;
  logic sctag_dram_rd_req_buf, sctag_dram_rd_dummy_req_buf, sctag_dram_wr_req_buf;
  logic [2:0] sctag_dram_rd_req_id_buf;
  logic [39:5] sctag_dram_addr_buf;
  logic scbuf_dram_data_vld_r5_buf;
  logic [WDW-1:0] scbuf_dram_wr_data_r5_buf;
  logic scbuf_dram_data_mecc_r5_buf;
  logic [CW-1:0] rep_rd_outstanding;
  logic rep_ovf_err, rep_unf_err, rep_par_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
  localparam logic [127:0] D2 = 128'hCAFEF00D_55AA55AA_12345678_0F0F0F0F;

  dram_sc_rep_pipe #(.STAGES(ST), .DW(DW), .EW(EW), .WDW(WDW), .MAX_OUTST(MO)) dut (
    .rclk(rclk), .reset(reset),
    .dram_scbuf_data_vld_r2(dram_scbuf_data_vld_r2), .dram_scbuf_data_r2(dram_scbuf_data_r2),
    .dram_scbuf_ecc_r2(dram_scbuf_ecc_r2), .dram_sctag_data_vld_r0(dram_sctag_data_vld_r0),
    .dram_sctag_chunk_id_r0(dram_sctag_chunk_id_r0), .dram_sctag_rd_req_id_r0(dram_sctag_rd_req_id_r0),
    .dram_sctag_rd_ack(dram_sctag_rd_ack), .dram_sctag_wr_ack(dram_sctag_wr_ack),
    .dram_sctag_secc_err_r2(dram_sctag_secc_err_r2), .dram_sctag_mecc_err_r2(dram_sctag_mecc_err_r2),
    .dram_sctag_scb_mecc_err(dram_sctag_scb_mecc_err), .dram_sctag_scb_secc_err(dram_sctag_scb_secc_err),
    .sctag_dram_rd_req(sctag_dram_rd_req), .sctag_dram_rd_dummy_req(sctag_dram_rd_dummy_req),
    .sctag_dram_wr_req(sctag_dram_wr_req), .sctag_dram_rd_req_id(sctag_dram_rd_req_id),
    .sctag_dram_addr(sctag_dram_addr), .scbuf_dram_data_vld_r5(scbuf_dram_data_vld_r5),
    .scbuf_dram_wr_data_r5(scbuf_dram_wr_data_r5), .scbuf_dram_data_mecc_r5(scbuf_dram_data_mecc_r5),
    .dram_scbuf_data_vld_r2_buf(dram_scbuf_data_vld_r2_buf), .dram_scbuf_data_r2_buf(dram_scbuf_data_r2_buf),
    .dram_scbuf_ecc_r2_buf(dram_scbuf_ecc_r2_buf), .dram_sctag_data_vld_r0_buf(dram_sctag_data_vld_r0_buf),
    .dram_sctag_chunk_id_r0_buf(dram_sctag_chunk_id_r0_buf), .dram_sctag_rd_req_id_r0_buf(dram_sctag_rd_req_id_r0_buf),
    .dram_sctag_rd_ack_buf(dram_sctag_rd_ack_buf), .dram_sctag_wr_ack_buf(dram_sctag_wr_ack_buf),
    .dram_sctag_secc_err_r2_buf(dram_sctag_secc_err_r2_buf), .dram_sctag_mecc_err_r2_buf(dram_sctag_mecc_err_r2_buf),
    .dram_sctag_scb_mecc_err_buf(dram_sctag_scb_mecc_err_buf), .dram_sctag_scb_secc_err_buf(dram_sctag_scb_secc_err_buf),
    .sctag_dram_rd_req_buf(sctag_dram_rd_req_buf), .sctag_dram_rd_dummy_req_buf(sctag_dram_rd_dummy_req_buf),
    .sctag_dram_wr_req_buf(sctag_dram_wr_req_buf), .sctag_dram_rd_req_id_buf(sctag_dram_rd_req_id_buf),
    .sctag_dram_addr_buf(sctag_dram_addr_buf), .scbuf_dram_data_vld_r5_buf(scbuf_dram_data_vld_r5_buf),
    .scbuf_dram_wr_data_r5_buf(scbuf_dram_wr_data_r5_buf), .scbuf_dram_data_mecc_r5_buf(scbuf_dram_data_mecc_r5_buf),
    .rep_rd_outstanding(rep_rd_outstanding), .rep_ovf_err(rep_ovf_err),
    .rep_unf_err(rep_unf_err), .rep_par_err(rep_par_err)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic set_all(input logic v);
    dram_scbuf_data_vld_r2  = v;
    dram_scbuf_data_r2      = {DW{v}};
    dram_scbuf_ecc_r2       = {EW{v}};
    dram_sctag_data_vld_r0  = v;
    dram_sctag_chunk_id_r0  = {2{v}};
    dram_sctag_rd_req_id_r0 = {3{v}};
    dram_sctag_rd_ack       = v;
    dram_sctag_wr_ack       = v;
    dram_sctag_secc_err_r2  = v;
    dram_sctag_mecc_err_r2  = v;
    dram_sctag_scb_mecc_err = v;
    dram_sctag_scb_secc_err = v;
    sctag_dram_rd_req       = v;
    sctag_dram_rd_dummy_req = v;
    sctag_dram_wr_req       = v;
    sctag_dram_rd_req_id    = {3{v}};
    sctag_dram_addr         = {35{v}};
    scbuf_dram_data_vld_r5  = v;
    scbuf_dram_wr_data_r5   = {WDW{v}};
    scbuf_dram_data_mecc_r5 = v;
  endtask

  initial begin
    // Reset with every input high
    set_all(1'b1);
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_vld_r2", dram_scbuf_data_vld_r2_buf, 0);
    chk("rst_data", dram_scbuf_data_r2_buf, 0);
    chk("rst_ecc", dram_scbuf_ecc_r2_buf, 0);
    chk("rst_vld_r0", dram_sctag_data_vld_r0_buf, 0);
    chk("rst_chunk", dram_sctag_chunk_id_r0_buf, 0);
    chk("rst_addr", sctag_dram_addr_buf, 0);
    chk("rst_rd_req", sctag_dram_rd_req_buf, 0);
    chk("rst_wr_data", scbuf_dram_wr_data_r5_buf, 0);
    chk("rst_cnt", rep_rd_outstanding, 0);
    chk("rst_ovf", rep_ovf_err, 0);
    chk("rst_unf", rep_unf_err, 0);
    chk("rst_par", rep_par_err, 0);
    set_all(1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_vld", dram_scbuf_data_vld_r2_buf, 0);
    chk("post_rst_ack", dram_sctag_rd_ack_buf, 0);
    chk("post_rst_req", sctag_dram_rd_req_buf, 0);
    chk("post_rst_cnt", rep_rd_outstanding, 0);

    // Return-data latency and hold
    dram_scbuf_data_vld_r2 = 1'b1;
    dram_scbuf_data_r2 = D1;
    dram_scbuf_ecc_r2 = 28'hABCDEF1;
    for (int c = 1; c <= ST + 2; c++) begin
      tick();
      dram_scbuf_data_vld_r2 = 1'b0;
      dram_scbuf_data_r2 = D2 ^ 128'(c);
      dram_scbuf_ecc_r2 = 28'(c);
      chk("lat_vld", dram_scbuf_data_vld_r2_buf, (c == ST) ? 1 : 0);
      chk("lat_par", rep_par_err, 0);
      if (c >= ST) begin
        chk("lat_data", dram_scbuf_data_r2_buf, D1);
        chk("lat_ecc", dram_scbuf_ecc_r2_buf, 28'hABCDEF1);
      end
    end

    // Back-to-back writes
    for (int c = 0; c <= ST + 4; c++) begin
      int j;
      scbuf_dram_data_vld_r5  = (c < 4);
      scbuf_dram_wr_data_r5   = (c < 4) ? 64'(c + 1) : 64'hFF;
      scbuf_dram_data_mecc_r5 = (c < 4) ? c[0] : 1'b0;
      tick();
      j = c - (ST - 1);
      chk("b2b_vld", scbuf_dram_data_vld_r5_buf, (j >= 0 && j < 4) ? 1 : 0);
      chk("b2b_data", scbuf_dram_wr_data_r5_buf, (j < 0) ? 0 : (j < 4) ? j + 1 : 4);
      chk("b2b_mecc", scbuf_dram_data_mecc_r5_buf, (j < 0) ? 0 : (j < 4) ? j % 2 : 1);
    end
    scbuf_dram_data_vld_r5 = 1'b0;

    // Nine reads with no acks: saturate at MO
    for (int i = 0; i < 9; i++) begin
      sctag_dram_rd_req = 1'b1;
      sctag_dram_addr = 35'h1_0000_0000 | 35'(i);
      sctag_dram_rd_req_id = 3'(i % 8);
      tick();
      chk("ovf_cnt", rep_rd_outstanding, (i + 1 > MO) ? MO : i + 1);
      chk("ovf_flag", rep_ovf_err, (i == 8) ? 1 : 0);
    end
    sctag_dram_rd_req = 1'b0;
    repeat (ST - 1) tick();
    chk("req_addr", sctag_dram_addr_buf, 35'h1_0000_0008);
    chk("req_id", sctag_dram_rd_req_id_buf, 0);
    chk("req_vld", sctag_dram_rd_req_buf, 1);

    // Dummy read does not count
    sctag_dram_rd_req = 1'b1;
    sctag_dram_rd_dummy_req = 1'b1;
    sctag_dram_addr = 35'h2_AAAA_5555;
    tick();
    sctag_dram_rd_req = 1'b0;
    sctag_dram_rd_dummy_req = 1'b0;
    chk("dummy_cnt", rep_rd_outstanding, MO);
    repeat (ST - 1) tick();
    chk("dummy_buf", sctag_dram_rd_dummy_req_buf, 1);
    chk("dummy_addr", sctag_dram_addr_buf, 35'h2_AAAA_5555);

    // Write request travels on the same group, counter unaffected
    sctag_dram_wr_req = 1'b1;
    sctag_dram_addr = 35'h0_1234_5678;
    sctag_dram_rd_req_id = 3'd3;
    tick();
    sctag_dram_wr_req = 1'b0;
    sctag_dram_addr = 35'h7_FFFF_FFFF;
    repeat (ST - 1) tick();
    chk("wr_req_buf", sctag_dram_wr_req_buf, 1);
    chk("wr_addr", sctag_dram_addr_buf, 35'h0_1234_5678);
    chk("wr_id", sctag_dram_rd_req_id_buf, 3);
    chk("wr_cnt", rep_rd_outstanding, MO);

    // Ack exits coincident with a new read: count unchanged
    dram_sctag_rd_ack = 1'b1;
    tick();
    dram_sctag_rd_ack = 1'b0;
    repeat (ST - 1) tick();
    chk("ack_buf", dram_sctag_rd_ack_buf, 1);
    sctag_dram_rd_req = 1'b1;
    tick();
    sctag_dram_rd_req = 1'b0;
    chk("ackreq_cnt", rep_rd_outstanding, MO);
    chk("ovf_sticky", rep_ovf_err, 1);

    // Lone ack decrements
    dram_sctag_rd_ack = 1'b1;
    tick();
    dram_sctag_rd_ack = 1'b0;
    repeat (ST) tick();
    chk("dec_cnt", rep_rd_outstanding, MO - 1);

    // Return tag and control pulses
    dram_sctag_data_vld_r0 = 1'b1;
    dram_sctag_chunk_id_r0 = 2'd2;
    dram_sctag_rd_req_id_r0 = 3'd6;
    dram_sctag_wr_ack = 1'b1;
    dram_sctag_secc_err_r2 = 1'b1;
    dram_sctag_mecc_err_r2 = 1'b1;
    dram_sctag_scb_mecc_err = 1'b1;
    dram_sctag_scb_secc_err = 1'b1;
    tick();
    set_all(1'b0);
    repeat (ST - 1) tick();
    chk("tag_vld", dram_sctag_data_vld_r0_buf, 1);
    chk("tag_chunk", dram_sctag_chunk_id_r0_buf, 2);
    chk("tag_id", dram_sctag_rd_req_id_r0_buf, 6);
    chk("pulses", {dram_sctag_wr_ack_buf, dram_sctag_secc_err_r2_buf, dram_sctag_mecc_err_r2_buf,
                   dram_sctag_scb_mecc_err_buf, dram_sctag_scb_secc_err_buf}, 5'b11111);
    tick();
    chk("tag_vld_drop", dram_sctag_data_vld_r0_buf, 0);
    chk("tag_chunk_hold", dram_sctag_chunk_id_r0_buf, 2);
    chk("pulses_drop", {dram_sctag_wr_ack_buf, dram_sctag_secc_err_r2_buf}, 0);

    // Underflow after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_cnt", rep_rd_outstanding, 0);
    chk("rst2_ovf", rep_ovf_err, 0);
    dram_sctag_rd_ack = 1'b1;
    for (int c = 1; c <= ST + 3; c++) begin
      tick();
      dram_sctag_rd_ack = 1'b0;
      chk("unf_flag", rep_unf_err, (c >= ST + 1) ? 1 : 0);
      chk("unf_cnt", rep_rd_outstanding, 0);
    end

    // Reset mid-flight discards everything
    dram_scbuf_data_vld_r2 = 1'b1;
    dram_scbuf_data_r2 = D2;
    sctag_dram_rd_req = 1'b1;
    tick();
    set_all(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= ST + 1; c++) begin
      tick();
      chk("mid_vld", dram_scbuf_data_vld_r2_buf, 0);
      chk("mid_data", dram_scbuf_data_r2_buf, 0);
      chk("mid_req", sctag_dram_rd_req_buf, 0);
      chk("mid_cnt", rep_rd_outstanding, 0);
      chk("mid_unf", rep_unf_err, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
